// File: rtl/mem_if_pkg.sv
// Shared main-memory interface constants used by the arbiter, the caches and
// the main-memory responder, plus the responder's FSM state encoding.
package mem_if_pkg;
  localparam int MEM_ADDR_BITS   = 28;
  localparam int MEM_DATA_BITS   = 128;
  localparam int MEM_TAG_BITS    = 5;
  localparam int MEM_DATA_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RRESP = 2'd3
  } mem_resp_state_e;
endpackage

// File: rtl/mem_beat_sram.sv
// Single-port beat store with per-byte write enables and a registered read,
// shaped so it can be swapped for an SRAM macro.
module mem_beat_sram #(
   parameter int DEPTH     = 16384,
   parameter int DATA_BITS = 128,
   parameter int IDX_BITS  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic [IDX_BITS-1:0]    addr,
   input  logic                   we,
   input  logic [DATA_BITS/8-1:0] wmask,
   input  logic [DATA_BITS-1:0]   wdata,
   output logic [DATA_BITS-1:0]   rdata
);
   logic [DATA_BITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < DATA_BITS / 8; b++) begin
         if (we && wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts line read/write requests, absorbs masked
// write beats and streams tagged read beats after a fixed latency.
//
// state    | meaning
// ST_IDLE  | ready for a request (ready rises one cycle after entry)
// ST_WDATA | absorbing BEATS write beats
// ST_RWAIT | counting down the read latency
// ST_RRESP | emitting BEATS response beats
module main_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_BITS    = MEM_ADDR_BITS,
  parameter int DATA_BITS    = MEM_DATA_BITS,
  parameter int TAG_BITS     = MEM_TAG_BITS,
  parameter int BEATS        = MEM_DATA_CYCLES,
  parameter int DEPTH        = 16384,
  parameter int READ_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);
  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

  mem_resp_state_e     state;
  logic [BEAT_W-1:0]   beat;
  logic [LAT_W-1:0]    lat_cnt;
  logic [IDX_BITS-1:0] base_q;
  logic [TAG_BITS-1:0] tag_q;
  logic [IDX_BITS-1:0] req_base;
  logic [IDX_BITS-1:0] sram_addr;
  logic                sram_we;
  logic [DATA_BITS-1:0] sram_rdata;
  logic                req_fire;
  logic                wbeat_fire;
  logic                last_beat;
  logic                unused_addr;

  assign req_base    = mem_req_addr[IDX_BITS-1:0] & ~IDX_BITS'(BEATS - 1);
  assign req_fire    = mem_req_valid & mem_req_ready;
  assign wbeat_fire  = mem_req_data_valid & mem_req_data_ready;
  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:IDX_BITS];

  // Read address runs one beat ahead of the response register to hide the
  // registered SRAM read; upper address bits alias modulo DEPTH.
  always_comb begin
    sram_addr = base_q;
    sram_we   = 1'b0;
    case (state)
      ST_IDLE:  sram_addr = req_base;
      ST_WDATA: begin
        sram_addr = base_q + IDX_BITS'(beat);
        sram_we   = wbeat_fire;
      end
      ST_RRESP: sram_addr = base_q + IDX_BITS'(beat) + IDX_BITS'(1);
      default:  sram_addr = base_q;
    endcase
  end

  mem_beat_sram #(
    .DEPTH     (DEPTH),
    .DATA_BITS (DATA_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_sram (
    .clk   (clk),
    .addr  (sram_addr),
    .we    (sram_we),
    .wmask (mem_req_data_mask),
    .wdata (mem_req_data_bits),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      mem_req_ready      <= 1'b0;
      mem_req_data_ready <= 1'b0;
      mem_resp_valid     <= 1'b0;
      mem_resp_data      <= '0;
      mem_resp_tag       <= '0;
      beat               <= '0;
      lat_cnt            <= '0;
      base_q             <= '0;
      tag_q              <= '0;
    end else begin
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
      mem_resp_tag   <= '0;
      case (state)
        ST_IDLE: begin
          mem_req_ready <= 1'b1;
          if (req_fire) begin
            mem_req_ready <= 1'b0;
            base_q        <= req_base;
            beat          <= '0;
            if (mem_req_rw) begin
              state              <= ST_WDATA;
              mem_req_data_ready <= 1'b1;
            end else begin
              tag_q <= mem_req_tag;
              if (READ_LATENCY == 1) begin
                state <= ST_RRESP;
              end else begin
                state   <= ST_RWAIT;
                lat_cnt <= LAT_W'(READ_LATENCY - 2);
              end
            end
          end
        end
        ST_WDATA: begin
          if (wbeat_fire) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state              <= ST_IDLE;
              mem_req_data_ready <= 1'b0;
              beat               <= '0;
            end
          end
        end
        ST_RWAIT: begin
          if (lat_cnt == '0) state <= ST_RRESP;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        ST_RRESP: begin
          mem_resp_valid <= 1'b1;
          mem_resp_data  <= sram_rdata;
          mem_resp_tag   <= tag_q;
          beat           <= beat + 1'b1;
          if (last_beat) begin
            state <= ST_IDLE;
            beat  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
